// File: rtl/digit_scan_ctrl_pkg.sv
// Shared types and constants for the digit scan controller and its select helper.
// Pure declarations; no timing or flow control here.
package digit_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_BLANK = 2'b01,
        S_SHOW  = 2'b10
    } state_t;

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Control/status bundle between a scan requester and digit_scan_ctrl.
// Level signals only; d0/d1/en feed the 2x4 decoder directly.
interface digit_scan_ctrl_if;
    import digit_scan_ctrl_pkg::*;

    logic                  start;
    logic                  stop;
    logic [NUM_DIGITS-1:0] digit_mask;
    logic                  d0;
    logic                  d1;
    logic                  en;
    logic                  busy;
    logic                  frame_done;

    modport master (
        output start, stop, digit_mask,
        input  d0, d1, en, busy, frame_done
    );

    modport slave (
        input  start, stop, digit_mask,
        output d0, d1, en, busy, frame_done
    );
endinterface

// File: rtl/digit_scan_ctrl_next_digit_sel.sv
// Circular priority search for the next enabled digit after (or at, when inclusive) i_cur_idx.
// Combinational; o_wrap flags a non-inclusive step that lands on a lower or equal index.
module digit_scan_ctrl_next_digit_sel
    import digit_scan_ctrl_pkg::*;
(
    input  logic [IDX_W-1:0]      i_cur_idx,
    input  logic [NUM_DIGITS-1:0] i_mask,
    input  logic                  i_incl,
    output logic [IDX_W-1:0]      o_nxt_idx,
    output logic                  o_wrap
);

    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    // Walk offsets from far to near so the nearest enabled digit overwrites the rest.
    always_comb begin
        o_nxt_idx = i_cur_idx;
        w_found   = 1'b0;
        w_cand    = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_cand = i_cur_idx + IDX_W'(k) + IDX_W'(!i_incl);
            if (i_mask[w_cand]) begin
                o_nxt_idx = w_cand;
                w_found   = 1'b1;
            end
        end
        o_wrap = w_found && !i_incl && (o_nxt_idx <= i_cur_idx);
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Steps decoder select/enable through the masked digits with a blanking gap before each slot.
// First en 1+BLANK_CYCLES cycles after start; stop takes effect only after the current slot.
module digit_scan_ctrl
    import digit_scan_ctrl_pkg::*;
#(
    parameter int PRESCALE     = 4,
    parameter int BLANK_CYCLES = 1,
    parameter int CNT_W        = 4
) (
    input  logic              i_clock,
    input  logic              i_resetn,
    digit_scan_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);

    state_t           r_state, w_nxt_state;
    logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
    logic [IDX_W-1:0] r_idx, w_nxt_idx;
    logic             r_stop_pend, w_nxt_stop_pend;
    logic             r_en, r_busy, r_frame_done;
    logic             w_frame_done;

    logic [IDX_W-1:0] w_sel_cur, w_sel_nxt;
    logic             w_sel_incl, w_sel_wrap;

    digit_scan_ctrl_next_digit_sel u_sel (
        .i_cur_idx (w_sel_cur),
        .i_mask    (bus.digit_mask),
        .i_incl    (w_sel_incl),
        .o_nxt_idx (w_sel_nxt),
        .o_wrap    (w_sel_wrap)
    );

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_cnt    = r_cnt;
        w_nxt_idx    = r_idx;
        w_frame_done = 1'b0;
        w_sel_cur    = r_idx;
        w_sel_incl   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_sel_cur  = '0;
                w_sel_incl = 1'b1;
                if (bus.start && !bus.stop && (bus.digit_mask != '0)) begin
                    w_nxt_state = S_BLANK;
                    w_nxt_cnt   = '0;
                    w_nxt_idx   = w_sel_nxt;
                end
            end
            S_BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    w_nxt_state = S_SHOW;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            S_SHOW: begin
                if (r_cnt != SHOW_LAST) begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end else if (r_stop_pend || bus.stop || (bus.digit_mask == '0)) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_cnt   = '0;
                    w_nxt_idx   = '0;
                end else begin
                    w_nxt_state  = S_BLANK;
                    w_nxt_cnt    = '0;
                    w_nxt_idx    = w_sel_nxt;
                    w_frame_done = w_sel_wrap;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_cnt   = '0;
                w_nxt_idx   = '0;
            end
        endcase
    end

    // A stop seen mid-scan is remembered until the slot ends; IDLE entry clears it.
    assign w_nxt_stop_pend = (w_nxt_state == S_IDLE) ? 1'b0
                           : (r_stop_pend || (bus.stop && (r_state != S_IDLE)));

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_stop_pend  <= 1'b0;
            r_en         <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_cnt        <= w_nxt_cnt;
            r_idx        <= w_nxt_idx;
            r_stop_pend  <= w_nxt_stop_pend;
            r_en         <= (w_nxt_state == S_SHOW);
            r_busy       <= (w_nxt_state != S_IDLE);
            r_frame_done <= w_frame_done;
        end
    end

    assign bus.d0         = r_idx[1];
    assign bus.d1         = r_idx[0];
    assign bus.en         = r_en;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl: expected slots queued at stimulus time, checked on each en rise.
module tb_digit_scan_ctrl;
    import digit_scan_ctrl_pkg::*;

    localparam int PRESCALE     = 4;
    localparam int BLANK_CYCLES = 1;

    typedef struct packed {
        logic [1:0] idx;
        logic       fd;
    } slot_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    digit_scan_ctrl_if bus ();

    digit_scan_ctrl #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES),
        .CNT_W        (4)
    ) dut (
        .i_clock  (clk),
        .i_resetn (rst_n),
        .bus      (bus)
    );

    slot_t exp_q[$];
    int    n_cmp    = 0;
    int    n_err    = 0;
    int    slot_cnt = 0;
    logic  fd_seen  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_next(input logic [1:0] cur, input logic [3:0] m);
        logic [1:0] c;
        for (int k = 1; k <= 4; k++) begin
            c = 2'((int'(cur) + k) % 4);
            if (m[c]) return c;
        end
        return cur;
    endfunction

    task automatic push_seq(input logic [3:0] m, input int n);
        logic [1:0] idx, nxt;
        idx = 2'd0;
        for (int k = 3; k >= 0; k--) if (m[k]) idx = 2'(k);
        exp_q.push_back('{idx: idx, fd: 1'b0});
        for (int s = 1; s < n; s++) begin
            nxt = model_next(idx, m);
            exp_q.push_back('{idx: nxt, fd: (nxt <= idx)});
            idx = nxt;
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin
        logic       prev_en;
        int         run_len, gap_len;
        logic [1:0] cur_sel;
        slot_t      e;
        prev_en = 1'b0; run_len = 0; gap_len = 0; cur_sel = 2'd0;
        forever begin
            @(negedge clk);
            if (bus.frame_done) fd_seen = 1'b1;
            if (bus.en && !prev_en) begin
                slot_cnt++;
                chk("exp_avail", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("slot_idx", {bus.d0, bus.d1}, e.idx);
                    chk("slot_fd", fd_seen, e.fd);
                end
                fd_seen = 1'b0;
                chk("blank_len", gap_len, BLANK_CYCLES);
                run_len = 1;
                cur_sel = {bus.d0, bus.d1};
            end else if (bus.en) begin
                run_len++;
                chk("sel_hold", {bus.d0, bus.d1}, cur_sel);
            end else if (prev_en && rst_n) begin
                chk("en_len", run_len, PRESCALE);
            end
            if (bus.busy && !bus.en) gap_len++;
            else gap_len = 0;
            prev_en = bus.en;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic stop_now();
        @(posedge clk); #1 bus.stop = 1'b1;
        @(posedge clk); #1 bus.stop = 1'b0;
    endtask

    task automatic wait_slot_cnt(input int target);
        int budget;
        budget = 300;
        while (slot_cnt < target && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        if (slot_cnt < target) chk("slot_timeout", slot_cnt, target);
    endtask

    task automatic end_scen(input string tag);
        int budget;
        budget = 100;
        @(negedge clk);
        while (bus.busy && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_en"}, bus.en, 0);
        chk({tag, "_sel"}, {bus.d0, bus.d1}, 0);
        chk({tag, "_q_left"}, exp_q.size(), 0);
        chk({tag, "_fd_idle"}, fd_seen, 0);
    endtask

    initial begin
        int base, lat;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.digit_mask = 4'b0000;
        #3;
        chk("rst_en", bus.en, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_sel", {bus.d0, bus.d1}, 0);
        chk("rst_fd", bus.frame_done, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Full mask: 0,1,2,3,0 with wrap pulse, plus start-to-en latency.
        base = slot_cnt;
        bus.digit_mask = 4'b1111;
        push_seq(4'b1111, 5);
        @(posedge clk); #1 bus.start = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1 bus.start = 1'b0;
            lat++;
        end while (!bus.en && lat < 20);
        chk("start_lat", lat, 1 + BLANK_CYCLES);
        wait_slot_cnt(base + 5);
        stop_now();
        end_scen("full");

        // Sparse mask 1010: 1,3,1,3.
        base = slot_cnt;
        bus.digit_mask = 4'b1010;
        push_seq(4'b1010, 4);
        pulse_start();
        wait_slot_cnt(base + 4);
        stop_now();
        end_scen("sparse");

        // Stop in second SHOW cycle of idx 2: slot completes, then idle.
        base = slot_cnt;
        bus.digit_mask = 4'b1111;
        push_seq(4'b1111, 3);
        pulse_start();
        wait_slot_cnt(base + 3);
        stop_now();
        end_scen("stop_mid");

        // Asynchronous reset mid SHOW, then restart from idx 0.
        base = slot_cnt;
        push_seq(4'b1111, 2);
        pulse_start();
        wait_slot_cnt(base + 2);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("arst_en", bus.en, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_sel", {bus.d0, bus.d1}, 0);
        chk("arst_fd", bus.frame_done, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        base = slot_cnt;
        push_seq(4'b1111, 2);
        pulse_start();
        wait_slot_cnt(base + 2);
        stop_now();
        end_scen("restart");

        // Empty mask: start ignored.
        bus.digit_mask = 4'b0000;
        pulse_start();
        repeat (4) @(negedge clk);
        chk("mask0_busy", bus.busy, 0);
        chk("mask0_en", bus.en, 0);

        // Mask cleared during the first slot: idle after that slot.
        base = slot_cnt;
        bus.digit_mask = 4'b1111;
        push_seq(4'b1111, 1);
        pulse_start();
        wait_slot_cnt(base + 1);
        bus.digit_mask = 4'b0000;
        end_scen("mask_clr");

        // start and stop together in IDLE: nothing happens.
        bus.digit_mask = 4'b1111;
        @(posedge clk); #1 begin bus.start = 1'b1; bus.stop = 1'b1; end
        @(posedge clk); #1 begin bus.start = 1'b0; bus.stop = 1'b0; end
        repeat (3) @(negedge clk);
        chk("startstop_busy", bus.busy, 0);
        chk("startstop_en", bus.en, 0);

        // Mask 1111 -> 0100 during idx 0 SHOW: next is 2, then 2 again with wrap.
        base = slot_cnt;
        exp_q.push_back('{idx: 2'd0, fd: 1'b0});
        exp_q.push_back('{idx: 2'd2, fd: 1'b0});
        exp_q.push_back('{idx: 2'd2, fd: 1'b1});
        pulse_start();
        wait_slot_cnt(base + 1);
        bus.digit_mask = 4'b0100;
        wait_slot_cnt(base + 3);
        stop_now();
        end_scen("mask_chg");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
